// File: rtl/ntt_pkg.sv
// ntt_pkg: transform mode encodings, twiddle prep FSM states and lane bit-reversal
package ntt_pkg;
    localparam logic [2:0] FORWARD_NTT_MODE = 3'd0;
    localparam logic [2:0] INVERSE_NTT_MODE = 3'd1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} prepState_t;
    function automatic int bitrev(input int k, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) r = r | (((k >> i) & 1) << (bits - 1 - i));
        return r;
    endfunction
endpackage

// File: rtl/twiddle_mod_halve.sv
// twiddle_mod_halve: combinational modular halving, w/2 mod Q for odd Q
module twiddle_mod_halve
    import ntt_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int Q = 8380417
) (
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] half
);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, w} + (w[0] ? (WIDTH+1)'(Q) : '0);
    assign half = sum[WIDTH:1];
endmodule

// File: rtl/twiddle_prep_pipe.sv
// twiddle_prep_pipe: valid/ready twiddle pre-processing (negate, INTT halving, INTT lane bit-reversal).
// Optional `TWIDDLE_RANGE_CHECK_EN adds a sticky w >= Q error flag and zeroes offending lanes.
module twiddle_prep_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int Q = 8380417,
    parameter int LANES = 8,
    parameter int HALVE_CNT = 1
) (
    input  logic                   ClkxCI,
    input  logic                   RstxRI,
    input  logic [2:0]             ModexSI,
    input  logic [LANES-1:0]       PrexSI,
    input  logic                   InValidxSI,
    output logic                   InReadyxSO,
    input  logic [LANES*WIDTH-1:0] InxDI,
    output logic                   OutValidxSO,
    input  logic                   OutReadyxSI,
    output logic [LANES*WIDTH-1:0] OutxDO,
    output logic [2:0]             OutModexSO,
    output logic                   BusyxSO,
    output logic                   ErrxSO
);
    localparam int LB = $clog2(LANES);
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

    prepState_t state, stateNext;
    logic [2:0] curMode, inMode, s1Mode, s2Mode;
    logic [LANES*WIDTH-1:0] inData, s1Data, s2Data, s3Data, negData, halveData;
    logic [LANES-1:0] s1Pre;
    logic s1Valid, s2Valid, s3Valid, s2Intt, s1Free, s2Free, s3Free, inFire, modeOk;
    logic [WIDTH-1:0] hv [LANES][HALVE_CNT+1];

    assign inMode = (ModexSI == INVERSE_NTT_MODE) ? INVERSE_NTT_MODE : FORWARD_NTT_MODE;
    assign s2Intt = s2Mode == INVERSE_NTT_MODE;
    // NTT beats leave from S2, INTT beats from S3; the drain FSM keeps the pipe single-mode
    assign s3Free = ~s3Valid | OutReadyxSI;
    assign s2Free = ~s2Valid | (s2Intt ? s3Free : OutReadyxSI);
    assign s1Free = ~s1Valid | s2Free;
    assign inFire = InValidxSI & InReadyxSO;
    assign BusyxSO = s1Valid | s2Valid | s3Valid;
    assign OutValidxSO = s3Valid | (s2Valid & ~s2Intt);
    assign OutxDO = s3Valid ? s3Data : s2Data;
    assign OutModexSO = s3Valid ? INVERSE_NTT_MODE : s2Mode;
    assign InReadyxSO = modeOk & s1Free & ~RstxRI;

    always_comb begin
        stateNext = state;
        modeOk = 1'b0;
        case (state)
            IDLE: begin
                modeOk = 1'b1;
                if (inFire) stateNext = RUN;
            end
            RUN: begin
                modeOk = ~InValidxSI | (inMode == curMode);
                if (~modeOk) stateNext = DRAIN;
                else if (~BusyxSO & ~InValidxSI) stateNext = IDLE;
            end
            default: if (~BusyxSO) stateNext = IDLE;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] w;
        assign w = s1Data[i*WIDTH +: WIDTH];
        assign negData[i*WIDTH +: WIDTH] = (s1Pre[i] && w != '0) ? QW - w : w;
        assign hv[i][0] = s2Data[i*WIDTH +: WIDTH];
        for (genvar j = 0; j < HALVE_CNT; j++) begin : g_halve
            twiddle_mod_halve #(.WIDTH(WIDTH), .Q(Q)) uHalve (.w(hv[i][j]), .half(hv[i][j+1]));
        end
        assign halveData[i*WIDTH +: WIDTH] = hv[bitrev(i, LB)][HALVE_CNT];
    end

`ifdef TWIDDLE_RANGE_CHECK_EN
    logic [LANES-1:0] inBad;
    logic errReg;
    for (genvar i = 0; i < LANES; i++) begin : g_chk
        assign inBad[i] = InxDI[i*WIDTH +: WIDTH] >= QW;
        assign inData[i*WIDTH +: WIDTH] = inBad[i] ? '0 : InxDI[i*WIDTH +: WIDTH];
    end
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) errReg <= 1'b0;
        else if (inFire && |inBad) errReg <= 1'b1;
    end
    assign ErrxSO = errReg;
`else
    assign inData = InxDI;
    assign ErrxSO = 1'b0;
`endif

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            state <= IDLE;
            curMode <= FORWARD_NTT_MODE;
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            s3Valid <= 1'b0;
            s1Data <= '0;
            s2Data <= '0;
            s3Data <= '0;
            s1Pre <= '0;
            s1Mode <= FORWARD_NTT_MODE;
            s2Mode <= FORWARD_NTT_MODE;
        end else begin
            state <= stateNext;
            if (inFire && state == IDLE) curMode <= inMode;
            if (s1Free) s1Valid <= inFire;
            if (inFire) begin
                s1Data <= inData;
                s1Pre <= PrexSI;
                s1Mode <= inMode;
            end
            if (s2Free) s2Valid <= s1Valid;
            if (s2Free && s1Valid) begin
                s2Data <= negData;
                s2Mode <= s1Mode;
            end
            if (s3Free) s3Valid <= s2Valid & s2Intt;
            if (s3Free && s2Valid && s2Intt) s3Data <= halveData;
        end
    end
endmodule

// File: tb/tb_twiddle_prep_pipe.sv
// tb_twiddle_prep_pipe: directed self-checking bench for twiddle_prep_pipe (WIDTH=23, Q=8380417, LANES=8, HALVE_CNT=1)
module tb_twiddle_prep_pipe;
    import ntt_pkg::*;
    localparam int W = 23;
    localparam int Q = 8380417;
    localparam int L = 8;

    logic ClkxCI = 1'b0;
    logic RstxRI;
    logic [2:0] ModexSI = '0;
    logic [L-1:0] PrexSI = '0;
    logic InValidxSI = 1'b0;
    logic InReadyxSO;
    logic [L*W-1:0] InxDI = '0;
    logic OutValidxSO;
    logic OutReadyxSI = 1'b1;
    logic [L*W-1:0] OutxDO;
    logic [2:0] OutModexSO;
    logic BusyxSO;
    logic ErrxSO;
    int passCnt = 0;
    int checkCnt = 0;

    twiddle_prep_pipe #(.WIDTH(W), .Q(Q), .LANES(L), .HALVE_CNT(1)) dut (
        .ClkxCI(ClkxCI), .RstxRI(RstxRI), .ModexSI(ModexSI), .PrexSI(PrexSI),
        .InValidxSI(InValidxSI), .InReadyxSO(InReadyxSO), .InxDI(InxDI),
        .OutValidxSO(OutValidxSO), .OutReadyxSI(OutReadyxSI), .OutxDO(OutxDO),
        .OutModexSO(OutModexSO), .BusyxSO(BusyxSO), .ErrxSO(ErrxSO)
    );

    always #5 ClkxCI = ~ClkxCI;

    function automatic logic [L*W-1:0] beat(input int b);
        logic [L*W-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = W'(b * 16 + i + 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic send_beat(input logic [2:0] m, input logic [L-1:0] p, input logic [L*W-1:0] d);
        bit acc;
        acc = 0;
        ModexSI = m;
        PrexSI = p;
        InxDI = d;
        InValidxSI = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1;
            acc = InReadyxSO;
            tick();
        end
        InValidxSI = 1'b0;
        checkCnt++;
        if (!acc) $display("FAIL send_beat: accepted=0 required 1"); else passCnt++;
    endtask

    task automatic test_reset();
        RstxRI = 1'b1;
        tick();
        tick();
        checkCnt++; if (OutValidxSO !== 1'b0) $display("FAIL rst_outvalid: got %b want 0", OutValidxSO); else passCnt++;
        checkCnt++; if (OutxDO !== '0) $display("FAIL rst_outdata: got %h want 0", OutxDO); else passCnt++;
        checkCnt++; if (OutModexSO !== 3'd0) $display("FAIL rst_outmode: got %0d want 0", OutModexSO); else passCnt++;
        checkCnt++; if (ErrxSO !== 1'b0) $display("FAIL rst_err: got %b want 0", ErrxSO); else passCnt++;
        checkCnt++; if (InReadyxSO !== 1'b0) $display("FAIL rst_inready: got %b want 0", InReadyxSO); else passCnt++;
        checkCnt++; if (BusyxSO !== 1'b0) $display("FAIL rst_busy: got %b want 0", BusyxSO); else passCnt++;
        RstxRI = 1'b0;
        tick();
    endtask

    task automatic test_ntt();
        logic [L*W-1:0] exp;
        exp = beat(0);
        exp[0 +: W] = W'(8380416);
        OutReadyxSI = 1'b1;
        send_beat(3'd0, 8'h01, beat(0));
        checkCnt++; if (OutValidxSO !== 1'b0) $display("FAIL ntt_early: got %b want 0", OutValidxSO); else passCnt++;
        tick();
        checkCnt++; if (OutValidxSO !== 1'b1) $display("FAIL ntt_valid: got %b want 1", OutValidxSO); else passCnt++;
        checkCnt++; if (OutxDO !== exp) $display("FAIL ntt_data: got %h want %h", OutxDO, exp); else passCnt++;
        checkCnt++; if (OutModexSO !== 3'd0) $display("FAIL ntt_tag: got %0d want 0", OutModexSO); else passCnt++;
        tick();
    endtask

    task automatic test_intt();
        logic [L*W-1:0] d, exp;
        d = '0;
        d[0 +: W] = W'(2);
        d[W +: W] = W'(1);
        exp = '0;
        exp[0 +: W] = W'(1);
        exp[4*W +: W] = W'(4190209);
        send_beat(3'd1, 8'h00, d);
        checkCnt++; if (OutValidxSO !== 1'b0) $display("FAIL intt_early1: got %b want 0", OutValidxSO); else passCnt++;
        tick();
        checkCnt++; if (OutValidxSO !== 1'b0) $display("FAIL intt_early2: got %b want 0", OutValidxSO); else passCnt++;
        tick();
        checkCnt++; if (OutValidxSO !== 1'b1) $display("FAIL intt_valid: got %b want 1", OutValidxSO); else passCnt++;
        checkCnt++; if (OutxDO !== exp) $display("FAIL intt_data: got %h want %h", OutxDO, exp); else passCnt++;
        checkCnt++; if (OutModexSO !== 3'd1) $display("FAIL intt_tag: got %0d want 1", OutModexSO); else passCnt++;
        tick();
    endtask

    task automatic test_zero_neg();
        send_beat(3'd0, 8'hFF, '0);
        tick();
        checkCnt++; if (OutValidxSO !== 1'b1) $display("FAIL zneg_valid: got %b want 1", OutValidxSO); else passCnt++;
        checkCnt++; if (OutxDO !== '0) $display("FAIL zneg_data: got %h want 0", OutxDO); else passCnt++;
        checkCnt++; if (OutModexSO !== 3'd0) $display("FAIL zneg_tag: got %0d want 0", OutModexSO); else passCnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int nIn, nOut;
        nIn = 0;
        nOut = 0;
        ModexSI = 3'd0;
        PrexSI = '0;
        for (int c = 0; c < 40 && nOut < 4; c++) begin
            OutReadyxSI = (c >= 5);
            InValidxSI = nIn < 4;
            InxDI = beat(nIn);
            #1;
            if (c == 4) begin
                checkCnt++; if (InReadyxSO !== 1'b0) $display("FAIL bp_inready: got %b want 0", InReadyxSO); else passCnt++;
                checkCnt++; if (nIn != 2) $display("FAIL bp_held: got %0d want 2", nIn); else passCnt++;
                checkCnt++; if (OutxDO !== beat(0)) $display("FAIL bp_stable: got %h want %h", OutxDO, beat(0)); else passCnt++;
            end
            if (OutValidxSO && OutReadyxSI) begin
                checkCnt++; if (OutxDO !== beat(nOut)) $display("FAIL bp_data%0d: got %h want %h", nOut, OutxDO, beat(nOut)); else passCnt++;
                checkCnt++; if (OutModexSO !== 3'd0) $display("FAIL bp_tag%0d: got %0d want 0", nOut, OutModexSO); else passCnt++;
                nOut++;
            end
            if (InValidxSI && InReadyxSO) nIn++;
            tick();
        end
        InValidxSI = 1'b0;
        OutReadyxSI = 1'b1;
        checkCnt++; if (nOut != 4) $display("FAIL bp_count: got %0d want 4", nOut); else passCnt++;
        tick();
    endtask

    task automatic test_mode_switch();
        int nIn, nOut, badReady;
        int t[8] = '{1, 5, 3, 7, 2, 6, 4, 8};
        logic [2:0] expTag;
        logic [L*W-1:0] inttIn, inttExp, expD;
        for (int i = 0; i < L; i++) begin
            inttIn[i*W +: W] = W'(2 * (i + 1));
            inttExp[i*W +: W] = W'(t[i]);
        end
        nIn = 0;
        nOut = 0;
        badReady = 0;
        OutReadyxSI = 1'b1;
        PrexSI = '0;
        for (int c = 0; c < 40 && nOut < 4; c++) begin
            InValidxSI = nIn < 4;
            ModexSI = (nIn == 3) ? 3'd1 : 3'd0;
            InxDI = (nIn == 3) ? inttIn : beat(nIn);
            #1;
            if (nIn == 3 && BusyxSO && InReadyxSO) badReady++;
            if (OutValidxSO) begin
                expTag = (nOut == 3) ? 3'd1 : 3'd0;
                expD = (nOut == 3) ? inttExp : beat(nOut);
                checkCnt++; if (OutModexSO !== expTag) $display("FAIL ms_tag%0d: got %0d want %0d", nOut, OutModexSO, expTag); else passCnt++;
                checkCnt++; if (OutxDO !== expD) $display("FAIL ms_data%0d: got %h want %h", nOut, OutxDO, expD); else passCnt++;
                nOut++;
            end
            if (InValidxSI && InReadyxSO) nIn++;
            tick();
        end
        InValidxSI = 1'b0;
        checkCnt++; if (badReady != 0) $display("FAIL ms_ready_busy: got %0d want 0", badReady); else passCnt++;
        checkCnt++; if (nOut != 4) $display("FAIL ms_count: got %0d want 4", nOut); else passCnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        OutReadyxSI = 1'b0;
        send_beat(3'd0, 8'h00, beat(5));
        send_beat(3'd0, 8'h00, beat(6));
        tick();
        RstxRI = 1'b1;
        #1;
        checkCnt++; if (OutValidxSO !== 1'b0) $display("FAIL rm_outvalid: got %b want 0", OutValidxSO); else passCnt++;
        checkCnt++; if (BusyxSO !== 1'b0) $display("FAIL rm_busy: got %b want 0", BusyxSO); else passCnt++;
        checkCnt++; if (InReadyxSO !== 1'b0) $display("FAIL rm_inready: got %b want 0", InReadyxSO); else passCnt++;
        checkCnt++; if (ErrxSO !== 1'b0) $display("FAIL rm_err: got %b want 0", ErrxSO); else passCnt++;
        tick();
        RstxRI = 1'b0;
        OutReadyxSI = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (OutValidxSO) stale++;
            tick();
        end
        checkCnt++; if (stale != 0) $display("FAIL rm_stale: got %0d want 0", stale); else passCnt++;
    endtask

`ifdef TWIDDLE_RANGE_CHECK_EN
    task automatic test_range();
        logic [L*W-1:0] d, exp;
        d = beat(2);
        d[3*W +: W] = W'(Q);
        exp = d;
        exp[3*W +: W] = '0;
        send_beat(3'd0, 8'h00, d);
        checkCnt++; if (ErrxSO !== 1'b1) $display("FAIL rng_err: got %b want 1", ErrxSO); else passCnt++;
        tick();
        checkCnt++; if (OutxDO !== exp) $display("FAIL rng_data: got %h want %h", OutxDO, exp); else passCnt++;
        tick();
        tick();
        checkCnt++; if (ErrxSO !== 1'b1) $display("FAIL rng_sticky: got %b want 1", ErrxSO); else passCnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_ntt();
        test_intt();
        test_zero_neg();
        test_back_to_back();
        test_mode_switch();
        test_reset_mid();
`ifdef TWIDDLE_RANGE_CHECK_EN
        test_range();
`endif
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
